dr_ald_pipe: RTL and testbench

Pipelined, signed dynamic-range approximate logarithmic divider (DR-ALD), the inverse of the DR-ALM multiplier core. Dividend and divisor are converted to the log domain: leading-one position plus a dynamically truncated mantissa. Exponents and mantissas are then subtracted, and the quotient is rebuilt by a Mitchell antilog shift. It sits beside the multiplier in the approximate-arithmetic datapath behind a valid/ready stream interface, with three register stages and full backpressure.

---
 rtl/dr_alm_pkg.sv | 35 +++
 rtl/lod_enc.sv | 22 ++
 rtl/dr_ald_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_dr_ald_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_alm_pkg.sv
// Shared package for the dynamic-range approximate log multiplier/divider
// datapath: default widths, the signed exponent type and the stage payloads
// that carry an operation between pipeline registers.
// Payload fields are sized from the package defaults. A module that narrows
// DWIDTH zero-extends into these fields.
package dr_alm_pkg;

    localparam int DR_DWIDTH      = 16;
    localparam int DR_TRUNC_WIDTH = 6;
    localparam int DR_FRAC_W      = 8;

    // Exponent difference spans -DWIDTH..DWIDTH-1, plus headroom for the borrow
    localparam int DR_EXP_W = $clog2(DR_DWIDTH) + 2;

    typedef logic signed [DR_EXP_W-1:0] exp_t;

    // Capture stage -> log/subtract stage
    typedef struct packed {
        logic                   sign_q;
        logic                   za;
        logic                   zb;
        logic [DR_DWIDTH-1:0]   abs_a;
        logic [DR_DWIDTH-1:0]   abs_b;
    } s1_payload_t;

    // Log/subtract stage -> antilog stage
    typedef struct packed {
        logic                       sign_q;
        logic                       za;
        logic                       zb;
        exp_t                       e;
        logic [DR_TRUNC_WIDTH-1:0]  frac;
    } s2_payload_t;

endpackage

// File: rtl/lod_enc.sv
// Parameterised leading-one detector: position of the highest set bit and a
// flag for an all-zero input (position reads 0 in that case). Shared between
// the log divider and the log multiplier.
module lod_enc #(
    parameter int W  = 16,
    parameter int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  val,
    output logic [PW-1:0] pos,
    output logic          zero
);

    // Scan from bit 0 upward so the highest set bit is the last one to win
    always_comb begin
        pos = {PW{1'b0}};
        for (int i = 0; i < W; i++) begin
            pos = val[i] ? PW'(i) : pos;
        end
        zero = (val == {W{1'b0}});
    end

endmodule

// File: rtl/dr_ald_pipe.sv
// Three-stage signed dynamic-range approximate logarithmic divider.
//   S1: sign, exact magnitudes, zero flags
//   S2: leading-one detection, truncated mantissas, log-domain subtraction
//   S3: Mitchell antilog shift, sign application, zero / divide-by-zero
// Valid/ready stream with full backpressure; bubbles collapse.
// Build option DR_ALD_DIVZERO_SAT_EN: a zero divisor saturates the quotient
// to +/-(2^(DWIDTH+FRAC_W)-1) instead of returning zero.
module dr_ald_pipe
    import dr_alm_pkg::*;
#(
    parameter int DWIDTH      = DR_DWIDTH,
    parameter int TRUNC_WIDTH = DR_TRUNC_WIDTH,
    parameter int FRAC_W      = DR_FRAC_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DWIDTH-1:0]       i_a,
    input  logic [DWIDTH-1:0]       i_b,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DWIDTH+FRAC_W:0]  o_q,
    output logic                    o_dz
);

    localparam int QW    = DWIDTH + 1 + FRAC_W;
    localparam int MAG_W = DWIDTH + FRAC_W;
    localparam int KW    = $clog2(DWIDTH);
    localparam int TM1   = TRUNC_WIDTH - 1;
    localparam int SW    = DR_EXP_W + 4;

    localparam logic signed [SW-1:0] S_OFF    = SW'(FRAC_W - TRUNC_WIDTH);
    localparam exp_t                 EXP_ONE  = exp_t'(1'b1);
    localparam logic [DWIDTH-1:0]    ONE_D    = {{(DWIDTH-1){1'b0}}, 1'b1};
    localparam logic [QW-1:0]        SAT_POS  = {1'b0, {MAG_W{1'b1}}};

    // Pipeline control
    logic v1_r, v2_r, v3_r;
    logic adv1_s, adv2_s, adv3_s;

    // Stage payloads
    s1_payload_t s1_next_s, s1_r;
    s2_payload_t s2_next_s, s2_r;

    // S2 working signals
    logic [DWIDTH-1:0]      abs_a_s, abs_b_s;
    logic [KW-1:0]          ka_s, kb_s;
    logic                   lz_a_s, lz_b_s;
    logic [TRUNC_WIDTH-1:0] xa_s, xb_s;
    logic [TRUNC_WIDTH:0]   fdiff_s;

    // S3 working signals
    logic [TRUNC_WIDTH:0]   m_s;
    logic [MAG_W-1:0]       ext_s, mag_s;
    logic signed [SW-1:0]   shift_s;
    logic [QW-1:0]          qmag_s, q_next_s, q_r;
    logic                   dz_next_s, dz_r;

    // Advance conditions; o_ready is combinational from i_ready through this chain
    always_comb begin
        adv3_s = !v3_r | i_ready;
        adv2_s = !v2_r | !v3_r | i_ready;
        adv1_s = !v1_r | !v2_r | adv2_s;
    end

    assign o_ready = !v1_r | adv1_s;
    assign o_valid = v3_r;
    assign o_q     = q_r;
    assign o_dz    = dz_r;

    // S1 capture: quotient sign, exact magnitudes (most negative maps to 2^(DWIDTH-1)), zero flags
    always_comb begin
        s1_next_s        = '0;
        s1_next_s.sign_q = i_a[DWIDTH-1] ^ i_b[DWIDTH-1];
        s1_next_s.za     = (i_a == {DWIDTH{1'b0}});
        s1_next_s.zb     = (i_b == {DWIDTH{1'b0}});
        if (i_a[DWIDTH-1]) begin
            s1_next_s.abs_a = DR_DWIDTH'(~i_a + ONE_D);
        end else begin
            s1_next_s.abs_a = DR_DWIDTH'(i_a);
        end
        if (i_b[DWIDTH-1]) begin
            s1_next_s.abs_b = DR_DWIDTH'(~i_b + ONE_D);
        end else begin
            s1_next_s.abs_b = DR_DWIDTH'(i_b);
        end
    end

    assign abs_a_s = DWIDTH'(s1_r.abs_a);
    assign abs_b_s = DWIDTH'(s1_r.abs_b);

    lod_enc #(
        .W  (DWIDTH),
        .PW (KW)
    ) u_lod_a (
        .val  (abs_a_s),
        .pos  (ka_s),
        .zero (lz_a_s)
    );

    lod_enc #(
        .W  (DWIDTH),
        .PW (KW)
    ) u_lod_b (
        .val  (abs_b_s),
        .pos  (kb_s),
        .zero (lz_b_s)
    );

    // S2 log conversion: normalise so the leading one sits at the MSB, keep the
    // t-1 bits beneath it, append a 1, then subtract with borrow into the exponent
    always_comb begin
        s2_next_s = '0;
        xa_s = {TM1'((abs_a_s << (KW'(DWIDTH - 1) - ka_s)) >> (DWIDTH - TRUNC_WIDTH)), 1'b1};
        xb_s = {TM1'((abs_b_s << (KW'(DWIDTH - 1) - kb_s)) >> (DWIDTH - TRUNC_WIDTH)), 1'b1};
        // Modulo-2^t difference already equals xa-xb+2^t when a borrow occurs
        fdiff_s = {1'b0, xa_s} - {1'b0, xb_s};
        s2_next_s.sign_q = s1_r.sign_q;
        // The detector's zero flag and the captured flag agree; either suffices
        s2_next_s.za     = s1_r.za | lz_a_s;
        s2_next_s.zb     = s1_r.zb | lz_b_s;
        s2_next_s.frac   = DR_TRUNC_WIDTH'(fdiff_s[TRUNC_WIDTH-1:0]);
        if (fdiff_s[TRUNC_WIDTH]) begin
            s2_next_s.e = exp_t'(ka_s) - exp_t'(kb_s) - EXP_ONE;
        end else begin
            s2_next_s.e = exp_t'(ka_s) - exp_t'(kb_s);
        end
    end

    // S3 antilog: m = 1.frac scaled by 2^(e+FRAC_W-t), then sign and zero overrides
    always_comb begin
        m_s     = {1'b1, TRUNC_WIDTH'(s2_r.frac)};
        ext_s   = MAG_W'(m_s);
        shift_s = SW'($signed(s2_r.e)) + S_OFF;
        if (!shift_s[SW-1]) begin
            mag_s = ext_s << shift_s;
        end else begin
            mag_s = ext_s >> (-shift_s);
        end
        qmag_s = QW'(mag_s);

        if (s2_r.zb) begin
            dz_next_s = 1'b1;
`ifdef DR_ALD_DIVZERO_SAT_EN
            // With b == 0 the quotient sign reduces to the sign of a; a == 0 is positive
            if (s2_r.sign_q) begin
                q_next_s = -SAT_POS;
            end else begin
                q_next_s = SAT_POS;
            end
`else
            q_next_s = {QW{1'b0}};
`endif
        end else if (s2_r.za) begin
            dz_next_s = 1'b0;
            q_next_s  = {QW{1'b0}};
        end else begin
            dz_next_s = 1'b0;
            if (s2_r.sign_q) begin
                q_next_s = -qmag_s;
            end else begin
                q_next_s = qmag_s;
            end
        end
    end

    // Stage valid bits; reset discards everything in flight
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            if (adv1_s) v1_r <= i_valid;
            if (adv2_s) v2_r <= v1_r;
            if (adv3_s) v3_r <= v2_r;
        end
    end

    // Stage payload registers, each loaded only when its stage advances
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            if (adv1_s) s1_r <= s1_next_s;
            if (adv2_s) s2_r <= s2_next_s;
        end
    end

    // Output register: holds while stalled, reads zero when a bubble moves in
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            q_r  <= {QW{1'b0}};
            dz_r <= 1'b0;
        end else if (adv3_s) begin
            if (v2_r) begin
                q_r  <= q_next_s;
                dz_r <= dz_next_s;
            end else begin
                q_r  <= {QW{1'b0}};
                dz_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dr_ald_pipe.sv
// Directed bench for dr_ald_pipe at default widths (16/6/8).
module tb_dr_ald_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [24:0] o_q;
    logic        o_dz;

    int vectors     = 0;
    int miscompares = 0;

`ifdef DR_ALD_DIVZERO_SAT_EN
    localparam logic signed [24:0] DZ_NEG = -25'sd16777215;
    localparam logic signed [24:0] DZ_POS =  25'sd16777215;
`else
    localparam logic signed [24:0] DZ_NEG = 25'sd0;
    localparam logic signed [24:0] DZ_POS = 25'sd0;
`endif

    // Nonzero operands: hand-derived Mitchell quotients in Q17.8
    logic signed [15:0] dv_a [8] = '{16'sd100, -16'sd48, 16'sd3, 16'sd8,
                                     -16'sd32768, 16'sd32767, 16'sd1, -16'sd1};
    logic signed [15:0] dv_b [8] = '{16'sd10, 16'sd16, 16'sd12, 16'sd12,
                                     16'sd1, 16'sd1, -16'sd32768, -16'sd1};
    logic signed [24:0] dv_q [8] = '{25'sd2688, -25'sd768, 25'sd64, 25'sd192,
                                     -25'sd8388608, 25'sd8257536, 25'sd0, 25'sd256};

    // Zero operands
    logic signed [15:0] zr_a  [5] = '{16'sd0, -16'sd7, 16'sd7, 16'sd0, 16'sd0};
    logic signed [15:0] zr_b  [5] = '{16'sd5, 16'sd0, 16'sd0, 16'sd0, -16'sd3};
    logic signed [24:0] zr_q  [5];
    logic               zr_dz [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Streaming / backpressure sequence
    logic signed [15:0] bp_a [4] = '{16'sd100, 16'sd3, 16'sd8, -16'sd48};
    logic signed [15:0] bp_b [4] = '{16'sd10, 16'sd12, 16'sd12, 16'sd16};
    logic signed [24:0] bp_q [4] = '{25'sd2688, 25'sd64, 25'sd192, -25'sd768};

    always #5 clk = ~clk;

    dr_ald_pipe #(
        .DWIDTH      (16),
        .TRUNC_WIDTH (6),
        .FRAC_W      (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_q     (o_q),
        .o_dz    (o_dz)
    );

    // Present one operand pair with i_ready high and wait (bounded) for its result
    task automatic issue_and_wait(input logic [15:0] a, input logic [15:0] b,
                                  output logic [24:0] q, output logic dz,
                                  output int lat, output logic rdy);
        @(negedge clk);
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        #1 rdy  = o_ready;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        #1;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
        end
        q  = o_q;
        dz = o_dz;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = 16'd0;
        i_b     = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
        vectors++;
        if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_o_ready: got %b expected 1", o_ready); end
        vectors++;
        if (o_q !== 25'd0) begin miscompares++; $display("FAIL reset_o_q: got %0d expected 0", $signed(o_q)); end
        vectors++;
        if (o_dz !== 1'b0) begin miscompares++; $display("FAIL reset_o_dz: got %b expected 0", o_dz); end
        rst_n = 1'b1;
    endtask

    task automatic test_divide();
        logic [24:0] q;
        logic        dz;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 8; i++) begin
            issue_and_wait(dv_a[i], dv_b[i], q, dz, lat, rdy);
            vectors++;
            if (rdy !== 1'b1) begin miscompares++; $display("FAIL divide_ready[%0d]: got %b expected 1", i, rdy); end
            vectors++;
            if (lat != 3) begin miscompares++; $display("FAIL divide_latency[%0d]: got %0d expected 3", i, lat); end
            vectors++;
            if ($signed(q) !== dv_q[i]) begin
                miscompares++;
                $display("FAIL divide_q[%0d] %0d/%0d: got %0d expected %0d", i, dv_a[i], dv_b[i], $signed(q), dv_q[i]);
            end
            vectors++;
            if (dz !== 1'b0) begin miscompares++; $display("FAIL divide_dz[%0d]: got %b expected 0", i, dz); end
        end
    endtask

    task automatic test_zero_operands();
        logic [24:0] q;
        logic        dz;
        int          lat;
        logic        rdy;
        zr_q[0] = 25'sd0;
        zr_q[1] = DZ_NEG;
        zr_q[2] = DZ_POS;
        zr_q[3] = DZ_POS;
        zr_q[4] = 25'sd0;
        for (int i = 0; i < 5; i++) begin
            issue_and_wait(zr_a[i], zr_b[i], q, dz, lat, rdy);
            vectors++;
            if (lat != 3) begin miscompares++; $display("FAIL zero_latency[%0d]: got %0d expected 3", i, lat); end
            vectors++;
            if ($signed(q) !== zr_q[i]) begin
                miscompares++;
                $display("FAIL zero_q[%0d] %0d/%0d: got %0d expected %0d", i, zr_a[i], zr_b[i], $signed(q), zr_q[i]);
            end
            vectors++;
            if (dz !== zr_dz[i]) begin miscompares++; $display("FAIL zero_dz[%0d]: got %b expected %b", i, dz, zr_dz[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int got   = 0;
        int first = -1;
        int last  = -1;
        i_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 4) begin
                i_valid = 1'b1;
                i_a     = bp_a[c];
                i_b     = bp_b[c];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (c < 4) begin
                vectors++;
                if (o_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected 1", c, o_ready); end
            end
            if (o_valid) begin
                if (got < 4) begin
                    vectors++;
                    if ($signed(o_q) !== bp_q[got]) begin
                        miscompares++;
                        $display("FAIL b2b_q[%0d]: got %0d expected %0d", got, $signed(o_q), bp_q[got]);
                    end
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            @(posedge clk);
        end
        vectors++;
        if (got != 4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", got); end
        vectors++;
        if (first != 3) begin miscompares++; $display("FAIL b2b_first_cycle: got %0d expected 3", first); end
        vectors++;
        if (last != 6) begin miscompares++; $display("FAIL b2b_last_cycle: got %0d expected 6", last); end
    endtask

    task automatic test_backpressure();
        int   idx = 0;
        int   got = 0;
        logic acc;
        i_ready = 1'b0;
        // Fill with the sink stalled
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_valid = (idx < 4);
            i_a     = bp_a[idx % 4];
            i_b     = bp_b[idx % 4];
            #1 acc  = i_valid & o_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        vectors++;
        if (idx != 3) begin miscompares++; $display("FAIL bp_accepts: got %0d expected 3", idx); end
        // Held while stalled
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (o_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low[%0d]: got %b expected 0", c, o_ready); end
            vectors++;
            if (o_valid !== 1'b1 || $signed(o_q) !== 25'sd2688) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b q=%0d expected valid=1 q=2688", c, o_valid, $signed(o_q));
            end
        end
        // Release and drain
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            i_ready = 1'b1;
            i_valid = (idx < 4);
            i_a     = bp_a[idx % 4];
            i_b     = bp_b[idx % 4];
            #1 acc  = i_valid & o_ready;
            if (o_valid) begin
                if (got < 4) begin
                    vectors++;
                    if ($signed(o_q) !== bp_q[got]) begin
                        miscompares++;
                        $display("FAIL bp_drain_q[%0d]: got %0d expected %0d", got, $signed(o_q), bp_q[got]);
                    end
                end
                got++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        i_valid = 1'b0;
        vectors++;
        if (got != 4) begin miscompares++; $display("FAIL bp_drain_count: got %0d expected 4", got); end
        vectors++;
        if (idx != 4) begin miscompares++; $display("FAIL bp_total_accepts: got %0d expected 4", idx); end
    endtask

    task automatic test_reset_midstream();
        int          seen = 0;
        logic [24:0] q;
        logic        dz;
        int          lat;
        logic        rdy;
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_a     = bp_a[c];
            i_b     = bp_b[c];
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (o_valid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_stalled_valid: got %b expected 1", o_valid); end
        i_valid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_o_valid: got %b expected 0", o_valid); end
        vectors++;
        if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_o_ready: got %b expected 1", o_ready); end
        vectors++;
        if (o_q !== 25'd0 || o_dz !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got q=%0d dz=%b expected q=0 dz=0", $signed(o_q), o_dz);
        end
        rst_n   = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (o_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL rst_mid_discard: got %0d stale results expected 0", seen); end
        issue_and_wait(16'd100, 16'd10, q, dz, lat, rdy);
        vectors++;
        if (lat != 3 || $signed(q) !== 25'sd2688 || dz !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_recover: got lat=%0d q=%0d dz=%b expected lat=3 q=2688 dz=0", lat, $signed(q), dz);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_zero_operands();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
